// File: rtl/elevador_descida.sv
// Return car controller: boards at floor B, descends, unloads at A, climbs back.
// Optional trip counter enabled by ELEVADOR_CONTADOR_EN.
module elevador_descida #(
  parameter int DIV_BITS   = 3,
  parameter int CAPACIDADE = 2,
  parameter int MAX_ESPERA = 2,
  parameter int T_VIAGEM   = 2
) (
  input  logic       clk_2,
  input  logic       reset_n,
  input  logic       pessoa,
  output logic       andar,
  output logic       porta,
  output logic [3:0] ocupantes,
  output logic [1:0] estado,
  output logic       tick,
  output logic [7:0] viagens
);

  typedef enum logic [1:0] {
    EMBARQUE_B    = 2'd0,
    DESCENDO      = 2'd1,
    DESEMBARQUE_A = 2'd2,
    SUBINDO       = 2'd3
  } estado_t;

  localparam logic [3:0] CAP     = 4'(CAPACIDADE);
  localparam logic [3:0] ESP_MAX = 4'(MAX_ESPERA);
  localparam logic [3:0] VIA_FIM = 4'(T_VIAGEM - 1);

  estado_t    est_q, est_d;
  logic [3:0] ocup_q, ocup_d;
  logic [3:0] esp_q, esp_d;
  logic       saida_fim;

  generate
    if (DIV_BITS == 0) begin : g_sem_div
      assign tick = 1'b1;
    end else begin : g_div
      logic [DIV_BITS-1:0] div_q;
      always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) div_q <= '0;
        else          div_q <= div_q + 1'b1;
      end
      assign tick = &div_q;
    end
  endgenerate

  // last unload tick: one tick per occupant
  assign saida_fim = (esp_q == ocup_q - 4'd1);

  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      est_q  <= EMBARQUE_B;
      ocup_q <= '0;
      esp_q  <= '0;
    end else begin
      est_q  <= est_d;
      ocup_q <= ocup_d;
      esp_q  <= esp_d;
    end
  end

  always_comb begin
    est_d  = est_q;
    ocup_d = ocup_q;
    esp_d  = esp_q;
    if (tick) begin
      unique case (est_q)
        EMBARQUE_B: begin
          if (ocup_q == CAP ||
              (ocup_q != '0 && esp_q == ESP_MAX)) begin
            est_d = DESCENDO;
            esp_d = '0;
          end else if (pessoa) begin
            ocup_d = ocup_q + 4'd1;
            esp_d  = '0;
          end else if (ocup_q != '0) begin
            esp_d = esp_q + 4'd1;
          end
        end
        DESCENDO, SUBINDO: begin
          if (esp_q == VIA_FIM) begin
            est_d = (est_q == DESCENDO) ?
                    DESEMBARQUE_A : EMBARQUE_B;
            esp_d = '0;
          end else begin
            esp_d = esp_q + 4'd1;
          end
        end
        DESEMBARQUE_A: begin
          if (saida_fim) begin
            est_d  = SUBINDO;
            ocup_d = '0;
            esp_d  = '0;
          end else begin
            esp_d = esp_q + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

`ifdef ELEVADOR_CONTADOR_EN
  logic [7:0] viag_q;
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n)
      viag_q <= '0;
    else if (tick && est_q == DESEMBARQUE_A && saida_fim)
      viag_q <= viag_q + 8'd1;
  end
  assign viagens = viag_q;
`else
  assign viagens = 8'h00;
`endif

  assign estado    = est_q;
  assign ocupantes = ocup_q;
  assign porta     = (est_q == EMBARQUE_B) ||
                     (est_q == DESEMBARQUE_A);
  assign andar     = (est_q == EMBARQUE_B) ||
                     (est_q == DESCENDO);

endmodule
